// File: rtl/cardinal_nic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cardinal_nic_pkg
// Brief    : Shared constants for the cardinal NIC: register map, data width,
//            status and drop-counter field positions (big-endian, bit 0 = MSB).
// Revision : 1.0 - initial release
// ============================================================================
package cardinal_nic_pkg;

    localparam int NIC_DATA_WIDTH = 64;

    localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

    // Full flag sits in the last (least significant) bit of a status word.
    localparam int NIC_STATUS_BIT  = 63;
    localparam int NIC_DROP_CNT_LO = 32;
    localparam int NIC_DROP_CNT_HI = 47;

endpackage
`default_nettype wire

// File: rtl/nic_chan_buf.sv
`default_nettype none
// ============================================================================
// Module   : nic_chan_buf
// Brief    : One-entry packet register with full flag; write wins over clear.
// Revision : 1.0 - initial release
// ============================================================================
module nic_chan_buf
    import cardinal_nic_pkg::*;
#(
    parameter int DATA_WIDTH = NIC_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [0:DATA_WIDTH-1] wdata,
    input  logic                  clr,
    output logic [0:DATA_WIDTH-1] rdata,
    output logic                  full
);

    logic [0:DATA_WIDTH-1] r_data;
    logic                  r_full;

    // Clearing only drops the flag; the payload stays readable as stale data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (wr) begin
            r_data <= wdata;
            r_full <= 1'b1;
        end else if (clr) begin
            r_full <= 1'b0;
        end
    end

    assign rdata = r_data;
    assign full  = r_full;

endmodule
`default_nettype wire

// File: rtl/cardinal_nic.sv
`default_nettype none
// ============================================================================
// Module   : cardinal_nic
// Brief    : Processor-to-ring NIC with one-packet input and output buffers.
//            Optional macro CARDINAL_NIC_DROP_CNT_EN adds a dropped-store counter.
// Revision : 1.0 - initial release
// ============================================================================
module cardinal_nic
    import cardinal_nic_pkg::*;
#(
    parameter int DATA_WIDTH = NIC_DATA_WIDTH,
    parameter int VC_BIT     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic [0:DATA_WIDTH-1] d_in,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);

    logic                  w_load;
    logic                  w_store;
    logic                  w_in_wr;
    logic                  w_in_clr;
    logic                  w_in_full;
    logic [0:DATA_WIDTH-1] w_in_buf;
    logic                  w_out_req;
    logic                  w_out_wr;
    logic                  w_out_full;
    logic [0:DATA_WIDTH-1] w_out_buf;
    logic [0:DATA_WIDTH-1] w_in_stat;
    logic [0:DATA_WIDTH-1] w_out_stat;

    assign w_load  = nicEn & ~nicWrEn;
    assign w_store = nicEn &  nicWrEn;

    // net_ri is low while full, so capture and read-clear never share an edge.
    assign w_in_wr  = net_si & ~w_in_full;
    assign w_in_clr = w_load & (addr == NIC_ADDR_IN_BUF) & w_in_full;

    // out_full is sampled before the edge: a store racing a send is dropped.
    assign w_out_req = w_store & (addr == NIC_ADDR_OUT_BUF);
    assign w_out_wr  = w_out_req & ~w_out_full;

    nic_chan_buf #(.DATA_WIDTH(DATA_WIDTH)) u_in_chan (
        .clk   (clk),
        .reset (reset),
        .wr    (w_in_wr),
        .wdata (net_di),
        .clr   (w_in_clr),
        .rdata (w_in_buf),
        .full  (w_in_full)
    );

    nic_chan_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out_chan (
        .clk   (clk),
        .reset (reset),
        .wr    (w_out_wr),
        .wdata (d_in),
        .clr   (net_so),
        .rdata (w_out_buf),
        .full  (w_out_full)
    );

    assign net_ri = ~w_in_full;
    assign net_do = w_out_buf;
    assign net_so = w_out_full & net_ro & (w_out_buf[VC_BIT] == net_polarity);

`ifdef CARDINAL_NIC_DROP_CNT_EN
    logic [15:0] r_drop_cnt;
    logic        w_out_drop;
    logic        w_cnt_clr;

    assign w_out_drop = w_out_req & w_out_full;
    assign w_cnt_clr  = w_store & (addr == NIC_ADDR_OUT_STAT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_drop_cnt <= '0;
        end else if (w_out_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end
`endif

    always_comb begin
        w_in_stat                  = '0;
        w_in_stat[NIC_STATUS_BIT]  = w_in_full;
        w_out_stat                 = '0;
        w_out_stat[NIC_STATUS_BIT] = w_out_full;
`ifdef CARDINAL_NIC_DROP_CNT_EN
        w_out_stat[NIC_DROP_CNT_LO:NIC_DROP_CNT_HI] = r_drop_cnt;
`endif
    end

    always_comb begin
        d_out = '0;
        if (w_load) begin
            case (addr)
                NIC_ADDR_IN_BUF:   d_out = w_in_buf;
                NIC_ADDR_IN_STAT:  d_out = w_in_stat;
                NIC_ADDR_OUT_BUF:  d_out = w_out_buf;
                default:           d_out = w_out_stat;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cardinal_nic.sv
`default_nettype none
// ============================================================================
// Module   : tb_cardinal_nic
// Brief    : Scoreboard bench for cardinal_nic; loads and sends are checked by
//            a negedge monitor against queued expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cardinal_nic;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;
    logic        net_polarity;

    int n_pass  = 0;
    int n_total = 0;

    logic [63:0] load_q[$];
    logic [63:0] send_q[$];
    logic [63:0] mon_exp;

    cardinal_nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] a, input logic [63:0] exp);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        load_q.push_back(exp);
        tick();
        nicEn = 1'b0;
    endtask

    task automatic store(input logic [1:0] a, input logic [63:0] data);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = data;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic wait_send(input string name);
        int k = 0;
        while (send_q.size() != 0 && k < 16) begin
            tick();
            k++;
        end
        check(name, 64'(send_q.size()), 64'd0);
        send_q.delete();
    endtask

    // Monitor: every load and every send must match the head of its queue.
    always @(negedge clk) begin
        if (nicEn && !nicWrEn) begin
            if (load_q.size() == 0) begin
                n_total++;
                $display("FAIL load_unexpected: got %h expected none", d_out);
            end else begin
                mon_exp = load_q.pop_front();
                check($sformatf("load_a%0d", addr), d_out, mon_exp);
            end
        end
        if (net_so) begin
            if (send_q.size() == 0) begin
                n_total++;
                $display("FAIL send_unexpected: got net_do %h expected no send", net_do);
            end else begin
                mon_exp = send_q.pop_front();
                check("send_data", net_do, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_si = 1'b1; net_di = 64'h1111_2222_3333_4444;
        net_ro = 1'b0; net_polarity = 1'b0;

        // Reset held with net_si asserted: nothing captured, all loads zero
        tick(); tick();
        check("rst_net_ri", 64'(net_ri), 64'd1);
        check("rst_net_so", 64'(net_so), 64'd0);
        check("rst_net_do", net_do, 64'd0);
        check("rst_d_out", d_out, 64'd0);
        load(2'b00, 64'd0);
        load(2'b01, 64'd0);
        load(2'b10, 64'd0);
        load(2'b11, 64'd0);

        // First edge after release captures net_di
        reset = 1'b1;
        tick();
        net_si = 1'b0;
        check("cap_net_ri", 64'(net_ri), 64'd0);
        load(2'b01, 64'd1);
        load(2'b00, 64'h1111_2222_3333_4444);
        load(2'b01, 64'd0);

        // Router packet, read-clear
        net_di = 64'hDEAD_BEEF_0000_0001; net_si = 1'b1;
        tick();
        net_si = 1'b0;
        load(2'b01, 64'd1);
        load(2'b00, 64'hDEAD_BEEF_0000_0001);
        load(2'b01, 64'd0);
        check("rx_net_ri", 64'(net_ri), 64'd1);
        load(2'b00, 64'hDEAD_BEEF_0000_0001);

        // Send gated by polarity (VC bit 0 = 1)
        net_ro = 1'b1; net_polarity = 1'b0;
        store(2'b10, 64'h8000_0000_0000_00AA);
        check("tx_wait_so", 64'(net_so), 64'd0);
        tick();
        check("tx_wait_so2", 64'(net_so), 64'd0);
        check("tx_net_do", net_do, 64'h8000_0000_0000_00AA);
        load(2'b11, 64'd1);
        send_q.push_back(64'h8000_0000_0000_00AA);
        net_polarity = 1'b1;
        wait_send("tx_send_done");
        net_polarity = 1'b0;
        load(2'b11, 64'd0);

        // Second store while full is dropped
        net_ro = 1'b0;
        store(2'b10, 64'h0123_4567_89AB_CDEF);
        store(2'b10, 64'hFEDC_BA98_7654_3210);
        check("drop_net_do", net_do, 64'h0123_4567_89AB_CDEF);
        load(2'b10, 64'h0123_4567_89AB_CDEF);
`ifdef CARDINAL_NIC_DROP_CNT_EN
        load(2'b11, 64'h0000_0000_0001_0001);
`else
        load(2'b11, 64'h0000_0000_0000_0001);
`endif
        send_q.push_back(64'h0123_4567_89AB_CDEF);
        net_ro = 1'b1;
        wait_send("drop_drain");
        net_ro = 1'b0;

        // Store racing a send completion is still dropped
        store(2'b10, 64'h0000_0000_0000_0C0C);
        send_q.push_back(64'h0000_0000_0000_0C0C);
        net_ro = 1'b1;
        store(2'b10, 64'h0000_0000_0000_0D0D);
        net_ro = 1'b0;
        check("race_net_do", net_do, 64'h0000_0000_0000_0C0C);
        check("race_send_q", 64'(send_q.size()), 64'd0);
`ifdef CARDINAL_NIC_DROP_CNT_EN
        load(2'b11, 64'h0000_0000_0002_0000);
`else
        load(2'b11, 64'h0000_0000_0000_0000);
`endif
        store(2'b11, 64'hFFFF_FFFF_FFFF_FFFF);
        load(2'b11, 64'd0);

        // Router packet while input buffer full
        net_di = 64'hAAAA_0000_0000_0005; net_si = 1'b1;
        tick();
        net_di = 64'h5555_0000_0000_0006;
        tick(); tick();
        check("busy_net_ri", 64'(net_ri), 64'd0);
        load(2'b01, 64'd1);
        load(2'b00, 64'hAAAA_0000_0000_0005);
        tick();
        net_si = 1'b0;
        load(2'b00, 64'h5555_0000_0000_0006);
        load(2'b01, 64'd0);

        // Reset while a send is pending discards it at once
        net_polarity = 1'b1;
        store(2'b10, 64'h8000_0000_0000_0006);
        reset = 1'b0; net_ro = 1'b1;
        #1;
        check("rst_mid_so", 64'(net_so), 64'd0);
        check("rst_mid_do", net_do, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        net_ro = 1'b0;
        load(2'b11, 64'd0);
        load(2'b10, 64'd0);

        tick();
        check("load_q_empty", 64'(load_q.size()), 64'd0);
        check("send_q_empty", 64'(send_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cardinal_nic.md
Name: cardinal_nic

Overview:
Network interface controller between the cardinal processor's NIC port and one ring-router port. It exposes four 2-bit-addressed registers to the processor:
- input buffer / input status (router -> processor)
- output buffer / output status (processor -> router)

Each direction holds one 64-bit packet with a full flag, so the processor can poll and move packets with plain loads and stores. Send and receive use ready/valid handshakes gated by the ring's even/odd polarity.

Parameters:
DATA_WIDTH, 64, packet and register width (big-endian bit order, bit 0 = MSB)
VC_BIT, 0, packet header bit carrying the virtual channel; compared with net_polarity

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
addr  input  2  register select: 00 in-buf, 01 in-status, 10 out-buf, 11 out-status
d_in  input  DATA_WIDTH  store data from processor
d_out  output  DATA_WIDTH  load data to processor
nicEn  input  1  access enable
nicWrEn  input  1  1 = store, 0 = load (valid only with nicEn)
net_si  input  1  router offers a packet to NIC
net_ri  output  1  NIC can accept a packet
net_di  input  DATA_WIDTH  packet from router
net_so  output  1  NIC sends packet this cycle
net_ro  input  1  router can accept a packet
net_do  output  DATA_WIDTH  packet to router
net_polarity  input  1  current ring phase

Behaviour:
- Reset (reset=0, asynchronous):
  - in_full=0, out_full=0, both buffers=0.
  - Outputs: net_ri=1, net_so=0, net_do=0, d_out=0.
- Input channel:
  - net_ri = ~in_full (combinational).
  - Capture on the clock edge where net_si & net_ri: in_buf<=net_di, in_full<=1.
  - net_si while in_full is ignored (the router must hold the packet).
- Processor load (nicEn=1, nicWrEn=0): d_out is combinational, zero-latency.
  - 00 returns in_buf.
  - 01 returns {63'b0, in_full}.
  - 10 returns out_buf.
  - 11 returns {63'b0, out_full}, with the upper field set by the optional feature.
  - d_out=0 when nicEn=0 or nicWrEn=1.
- Load of 00 with in_full=1 clears in_full at that edge; the buffer content is retained.
  - Load of 00 with in_full=0 returns stale data and changes no state.
  - Read-clear and capture cannot coincide, because net_ri=0 while full.
- Processor store (nicEn=1, nicWrEn=1):
  - Store to 10 with out_full=0: out_buf<=d_in, out_full<=1.
  - Store to 10 with out_full=1 is dropped; the buffer is unchanged.
  - Stores to 00, 01 and 11 are ignored.
- Output channel:
  - net_do = out_buf.
  - net_so = out_full & net_ro & (out_buf[VC_BIT]==net_polarity), combinational.
  - On an edge with net_so=1, out_full<=0.
- Simultaneous send-completion and store to 10 in the same cycle: the store is still dropped (out_full is sampled before the edge). Software must re-poll.
- One packet in flight per direction; sustained throughput ≤1 packet per 2 cycles per direction.
- Reset asserted mid-transfer discards any buffered packets immediately.

Optional Feature:
CARDINAL_NIC_DROP_CNT_EN
- Defined:
  - A 16-bit saturating counter drop_cnt increments on every dropped store to 10.
  - It saturates at 16'hFFFF and resets to 0.
  - A load of 11 returns drop_cnt in bits [32:47].
  - A store to 11 clears drop_cnt.
- Undefined: no counter; bits [32:47] of an address-11 load read 0; stores to 11 are ignored.

Decomposition:
- Package cardinal_nic_pkg:
  - Address constants NIC_ADDR_IN_BUF=2'b00, NIC_ADDR_IN_STAT=2'b01, NIC_ADDR_OUT_BUF=2'b10, NIC_ADDR_OUT_STAT=2'b11.
  - DATA_WIDTH default.
  - Status bit position (63).
- Sub-module nic_chan_buf: one-entry register plus full flag.
  - Ports: wr, wdata, clr, rdata, full.
  - Instantiated twice: input channel and output channel.

Test Plan:
1. Reset with net_si=1 held -> net_ri=1, net_so=0, all loads return 0; on release, first edge captures net_di.
2. Router sends 64'hDEAD_BEEF_0000_0001 -> load 01 returns 1; load 00 returns the packet; next load 01 returns 0; net_ri back to 1.
3. Store 64'h8000_0000_0000_00AA to 10, net_ro=1 -> net_so stays 0 while net_polarity=0, asserts on the first cycle net_polarity=1; load 11 then returns 0.
4. Store 10 with net_ro=0, then a second store of a different value -> net_do keeps the first value. With CARDINAL_NIC_DROP_CNT_EN, load 11 bits [32:47]=1.
5. Second router packet while in_full=1 -> net_ri=0, in_buf unchanged until the processor loads 00.
6. Assert reset while out_full=1 and net_ro=1 -> net_so drops the same cycle; after release, load 11 returns 0.
